te_block_expander: RTL and testbench

TE_BLOCK_EXPANDER -- requirements
Module: te_block_expander

---
 rtl/mure_pkg.sv | 8 +
 rtl/te_block_expander_if.sv | 47 ++++
 rtl/te_block_expander.sv | 158 +++++++++++++++
 tb/tb_te_block_expander.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mure_pkg.sv
// Shared trace-field widths for the trace encoder blocks.
package mure_pkg;
    parameter int XLEN        = 32;
    parameter int IRETIRE_LEN = 8;
    parameter int ITYPE_LEN   = 3;
    parameter int CAUSE_LEN   = 5;
    parameter int PRIV_LEN    = 2;
endpackage

// File: rtl/te_block_expander_if.sv
// Bundle of the trace-block input channel, the length-lookup port and the
// per-instruction output beat channel of te_block_expander.
interface te_block_expander_if;
    import mure_pkg::*;

    logic                   block_valid_i;
    logic                   block_ready_o;
    logic [IRETIRE_LEN-1:0] iretire_i;
    logic                   ilastsize_i;
    logic [ITYPE_LEN-1:0]   itype_i;
    logic [CAUSE_LEN-1:0]   cause_i;
    logic [XLEN-1:0]        tval_i;
    logic [PRIV_LEN-1:0]    priv_i;
    logic [XLEN-1:0]        iaddr_i;

    logic [XLEN-1:0]        query_addr_o;
    logic                   query_compressed_i;

    logic                   insn_valid_o;
    logic                   insn_ready_i;
    logic [XLEN-1:0]        insn_pc_o;
    logic                   insn_compressed_o;
    logic                   insn_ret_o;
    logic                   insn_last_o;
    logic [ITYPE_LEN-1:0]   insn_itype_o;
    logic [PRIV_LEN-1:0]    insn_priv_o;
    logic                   exc_valid_o;
    logic [CAUSE_LEN-1:0]   cause_o;
    logic [XLEN-1:0]        tval_o;
    logic                   err_o;

    modport slave (
        input  block_valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i,
               priv_i, iaddr_i, query_compressed_i, insn_ready_i,
        output block_ready_o, query_addr_o, insn_valid_o, insn_pc_o,
               insn_compressed_o, insn_ret_o, insn_last_o, insn_itype_o,
               insn_priv_o, exc_valid_o, cause_o, tval_o, err_o
    );

    modport master (
        output block_valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i,
               priv_i, iaddr_i, query_compressed_i, insn_ready_i,
        input  block_ready_o, query_addr_o, insn_valid_o, insn_pc_o,
               insn_compressed_o, insn_ret_o, insn_last_o, insn_itype_o,
               insn_priv_o, exc_valid_o, cause_o, tval_o, err_o
    );
endinterface

// File: rtl/te_block_expander.sv
// Expands one retired-instruction trace block into a stream of per-instruction
// beats, using a same-cycle length lookup to walk the PC through the block.
module te_block_expander
    import mure_pkg::*;
#(
    parameter bit CHECK_LASTSIZE = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    te_block_expander_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXPAND, EXC} state_t;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [IRETIRE_LEN-1:0] rem_q, rem_d;
    logic                   ilastsize_q, ilastsize_d;
    logic [ITYPE_LEN-1:0]   itype_q, itype_d;
    logic [CAUSE_LEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]        tval_q, tval_d;
    logic [PRIV_LEN-1:0]    priv_q, priv_d;
    logic                   err_q, err_d;

    logic [IRETIRE_LEN-1:0] sz;
    logic [XLEN-1:0]        step;
    logic                   latched_exc;
    logic                   incoming_exc;

    always_comb begin
        sz           = bus.query_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
        step         = bus.query_compressed_i ? XLEN'(2) : XLEN'(4);
        latched_exc  = (itype_q == ITYPE_LEN'(1)) || (itype_q == ITYPE_LEN'(2));
        incoming_exc = (bus.itype_i == ITYPE_LEN'(1)) || (bus.itype_i == ITYPE_LEN'(2));

        state_d     = state_q;
        pc_d        = pc_q;
        rem_d       = rem_q;
        ilastsize_d = ilastsize_q;
        itype_d     = itype_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        priv_d      = priv_q;
        err_d       = err_q;

        bus.block_ready_o     = 1'b0;
        bus.query_addr_o      = '0;
        bus.insn_valid_o      = 1'b0;
        bus.insn_pc_o         = '0;
        bus.insn_compressed_o = 1'b0;
        bus.insn_ret_o        = 1'b0;
        bus.insn_last_o       = 1'b0;
        bus.insn_itype_o      = '0;
        bus.insn_priv_o       = '0;
        bus.exc_valid_o       = 1'b0;
        bus.cause_o           = '0;
        bus.tval_o            = '0;
        bus.err_o             = err_q;

        case (state_q)
            IDLE: begin
                // Ready is held low while reset is asserted so nothing is accepted then.
                bus.block_ready_o = ~rst_i;
                if (bus.block_valid_i && !rst_i) begin
                    pc_d        = bus.iaddr_i;
                    rem_d       = bus.iretire_i;
                    ilastsize_d = bus.ilastsize_i;
                    itype_d     = bus.itype_i;
                    cause_d     = bus.cause_i;
                    tval_d      = bus.tval_i;
                    priv_d      = bus.priv_i;
                    if (bus.iretire_i != '0) begin
                        state_d = EXPAND;
                    end else if (incoming_exc) begin
                        state_d = EXC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXPAND: begin
                bus.query_addr_o = pc_q;
                if (rem_q < sz) begin
                    // A 4-byte instruction cannot fit in the single halfword left.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    bus.insn_valid_o      = 1'b1;
                    bus.insn_pc_o         = pc_q;
                    bus.insn_compressed_o = bus.query_compressed_i;
                    bus.insn_ret_o        = 1'b1;
                    bus.insn_last_o       = (rem_q == sz);
                    bus.insn_priv_o       = priv_q;
                    if (rem_q == sz) begin
                        bus.insn_itype_o = itype_q;
                        if (latched_exc) begin
                            bus.exc_valid_o = 1'b1;
                            bus.cause_o     = cause_q;
                            bus.tval_o      = tval_q;
                        end
                    end
                    if (bus.insn_ready_i) begin
                        pc_d  = pc_q + step;
                        rem_d = rem_q - sz;
                        if (rem_q == sz) begin
                            state_d = IDLE;
                            // ilastsize=1 means 4 bytes, i.e. a compressed last beat disagrees.
                            if (CHECK_LASTSIZE && (bus.query_compressed_i == ilastsize_q)) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
            end
            EXC: begin
                bus.insn_valid_o = 1'b1;
                bus.insn_pc_o    = pc_q;
                bus.insn_last_o  = 1'b1;
                bus.insn_itype_o = itype_q;
                bus.insn_priv_o  = priv_q;
                bus.exc_valid_o  = 1'b1;
                bus.cause_o      = cause_q;
                bus.tval_o       = tval_q;
                if (bus.insn_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            rem_q       <= '0;
            ilastsize_q <= 1'b0;
            itype_q     <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            priv_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rem_q       <= rem_d;
            ilastsize_q <= ilastsize_d;
            itype_q     <= itype_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            priv_q      <= priv_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_te_block_expander.sv
// Directed bench for te_block_expander: each task drives one scenario and
// checks the beat stream against hand-computed values.
module tb_te_block_expander;
    import mure_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    te_block_expander_if bus ();

    te_block_expander #(.CHECK_LASTSIZE(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {insn_valid, insn_ret, insn_last, insn_compressed, exc_valid}
    function automatic logic [4:0] flags();
        return {bus.insn_valid_o, bus.insn_ret_o, bus.insn_last_o,
                bus.insn_compressed_o, bus.exc_valid_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic accept(input logic [XLEN-1:0] addr, input logic [IRETIRE_LEN-1:0] ret,
                          input logic lastsz, input logic [ITYPE_LEN-1:0] ty,
                          input logic [CAUSE_LEN-1:0] cs, input logic [XLEN-1:0] tv,
                          input logic [PRIV_LEN-1:0] pv);
        bus.iaddr_i       = addr;
        bus.iretire_i     = ret;
        bus.ilastsize_i   = lastsz;
        bus.itype_i       = ty;
        bus.cause_i       = cs;
        bus.tval_i        = tv;
        bus.priv_i        = pv;
        bus.block_valid_i = 1'b1;
        step();
        bus.block_valid_i = 1'b0;
        $display("block addr=%h iretire=%0d itype=%0d", addr, ret, ty);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        total++;
        if ({bus.block_ready_o, flags(), bus.err_o, bus.query_addr_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ready=%b flags=%b err=%b qa=%h want all 0",
                     bus.block_ready_o, flags(), bus.err_o, bus.query_addr_o);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.block_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=1", bus.block_ready_o);
        end
        step();
    endtask

    task automatic test_expand();
        logic [XLEN-1:0] pcs [3] = '{32'h1000, 32'h1004, 32'h1006};
        logic            cmp [3] = '{1'b0, 1'b1, 1'b0};
        logic            lst [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        accept(32'h1000, 8'd5, 1'b1, 3'd0, 5'd0, 32'h0, 2'd3);
        for (int i = 0; i < 3; i++) begin
            bus.query_compressed_i = cmp[i];
            @(negedge clk);
            $display("beat pc=%h last=%b", bus.insn_pc_o, bus.insn_last_o);
            total++;
            if ({bus.insn_pc_o, bus.query_addr_o, flags(), bus.insn_itype_o, bus.insn_priv_o}
                !== {pcs[i], pcs[i], 1'b1, 1'b1, lst[i], cmp[i], 1'b0, 3'd0, 2'd3}) begin
                bad++;
                $display("FAIL expand_beat%0d got pc=%h qa=%h flags=%b itype=%0d priv=%0d want pc=%h last=%b cmp=%b",
                         i, bus.insn_pc_o, bus.query_addr_o, flags(), bus.insn_itype_o,
                         bus.insn_priv_o, pcs[i], lst[i], cmp[i]);
            end
            step();
        end
        @(negedge clk);
        total++;
        if ({bus.insn_valid_o, bus.block_ready_o, bus.err_o} !== 3'b010) begin
            bad++;
            $display("FAIL expand_after got valid=%b ready=%b err=%b want 0 1 0",
                     bus.insn_valid_o, bus.block_ready_o, bus.err_o);
        end
        step();
    endtask

    task automatic test_exception();
        do_reset();
        accept(32'h2000, 8'd0, 1'b0, 3'd1, 5'd2, 32'hDEAD, 2'd1);
        @(negedge clk);
        $display("beat pc=%h exc=%b cause=%0d", bus.insn_pc_o, bus.exc_valid_o, bus.cause_o);
        total++;
        if ({flags(), bus.insn_pc_o, bus.cause_o, bus.tval_o, bus.insn_itype_o, bus.insn_priv_o}
            !== {5'b10101, 32'h2000, 5'd2, 32'hDEAD, 3'd1, 2'd1}) begin
            bad++;
            $display("FAIL exc_beat got flags=%b pc=%h cause=%0d tval=%h itype=%0d priv=%0d want flags=10101 pc=2000 cause=2 tval=dead",
                     flags(), bus.insn_pc_o, bus.cause_o, bus.tval_o, bus.insn_itype_o, bus.insn_priv_o);
        end
        step();
        @(negedge clk);
        total++;
        if ({bus.insn_valid_o, bus.exc_valid_o, bus.block_ready_o, bus.err_o} !== 4'b0010) begin
            bad++;
            $display("FAIL exc_after got valid=%b exc=%b ready=%b err=%b want 0 0 1 0",
                     bus.insn_valid_o, bus.exc_valid_o, bus.block_ready_o, bus.err_o);
        end
        step();
        // interrupt carried on the last retired beat of an expanding block
        accept(32'h2100, 8'd1, 1'b0, 3'd2, 5'd7, 32'h55, 2'd0);
        bus.query_compressed_i = 1'b1;
        @(negedge clk);
        $display("beat pc=%h exc=%b", bus.insn_pc_o, bus.exc_valid_o);
        total++;
        if ({flags(), bus.cause_o, bus.tval_o, bus.insn_itype_o} !== {5'b11111, 5'd7, 32'h55, 3'd2}) begin
            bad++;
            $display("FAIL irq_last_beat got flags=%b cause=%0d tval=%h itype=%0d want flags=11111 cause=7 tval=55 itype=2",
                     flags(), bus.cause_o, bus.tval_o, bus.insn_itype_o);
        end
        step();
        @(negedge clk);
        total++;
        if (bus.err_o !== 1'b0) begin
            bad++;
            $display("FAIL irq_err got=%b want=0", bus.err_o);
        end
        step();
    endtask

    task automatic test_bad_itype();
        do_reset();
        accept(32'h8000, 8'd0, 1'b0, 3'd3, 5'd0, 32'h0, 2'd0);
        @(negedge clk);
        total++;
        if ({bus.insn_valid_o, bus.block_ready_o, bus.err_o} !== 3'b011) begin
            bad++;
            $display("FAIL bad_itype got valid=%b ready=%b err=%b want 0 1 1",
                     bus.insn_valid_o, bus.block_ready_o, bus.err_o);
        end
        step();
    endtask

    task automatic test_underflow();
        do_reset();
        accept(32'h3000, 8'd3, 1'b1, 3'd0, 5'd0, 32'h0, 2'd0);
        bus.query_compressed_i = 1'b0;
        @(negedge clk);
        $display("beat pc=%h last=%b", bus.insn_pc_o, bus.insn_last_o);
        total++;
        if ({flags(), bus.insn_pc_o} !== {5'b11000, 32'h3000}) begin
            bad++;
            $display("FAIL underflow_beat got flags=%b pc=%h want flags=11000 pc=3000", flags(), bus.insn_pc_o);
        end
        step();
        @(negedge clk);
        total++;
        if (bus.insn_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL underflow_no_beat got valid=%b want=0", bus.insn_valid_o);
        end
        step();
        @(negedge clk);
        total++;
        if ({bus.err_o, bus.block_ready_o, bus.insn_valid_o} !== 3'b110) begin
            bad++;
            $display("FAIL underflow_err got err=%b ready=%b valid=%b want 1 1 0",
                     bus.err_o, bus.block_ready_o, bus.insn_valid_o);
        end
        step();
    endtask

    task automatic test_lastsize();
        do_reset();
        accept(32'h4000, 8'd2, 1'b1, 3'd0, 5'd0, 32'h0, 2'd0);
        bus.query_compressed_i = 1'b1;
        step();
        @(negedge clk);
        $display("beat pc=%h last=%b", bus.insn_pc_o, bus.insn_last_o);
        total++;
        if ({flags(), bus.insn_pc_o, bus.err_o} !== {5'b11110, 32'h4002, 1'b0}) begin
            bad++;
            $display("FAIL lastsize_beat got flags=%b pc=%h err=%b want flags=11110 pc=4002 err=0",
                     flags(), bus.insn_pc_o, bus.err_o);
        end
        step();
        @(negedge clk);
        total++;
        if (bus.err_o !== 1'b1) begin
            bad++;
            $display("FAIL lastsize_err got=%b want=1", bus.err_o);
        end
        step();
    endtask

    task automatic test_stall();
        do_reset();
        accept(32'h5000, 8'd4, 1'b1, 3'd0, 5'd0, 32'h0, 2'd2);
        bus.query_compressed_i = 1'b1;
        step();
        bus.insn_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({flags(), bus.insn_pc_o, bus.insn_priv_o} !== {5'b11010, 32'h5002, 2'd2}) begin
                bad++;
                $display("FAIL stall_hold%0d got flags=%b pc=%h priv=%0d want flags=11010 pc=5002 priv=2",
                         i, flags(), bus.insn_pc_o, bus.insn_priv_o);
            end
            step();
        end
        bus.insn_ready_i = 1'b1;
        step();
        bus.query_compressed_i = 1'b0;
        @(negedge clk);
        $display("beat pc=%h last=%b", bus.insn_pc_o, bus.insn_last_o);
        total++;
        if ({flags(), bus.insn_pc_o} !== {5'b11100, 32'h5004}) begin
            bad++;
            $display("FAIL stall_last got flags=%b pc=%h want flags=11100 pc=5004", flags(), bus.insn_pc_o);
        end
        step();
        @(negedge clk);
        total++;
        if ({bus.insn_valid_o, bus.err_o} !== 2'b00) begin
            bad++;
            $display("FAIL stall_after got valid=%b err=%b want 0 0", bus.insn_valid_o, bus.err_o);
        end
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        accept(32'hFFFF_FFFE, 8'd2, 1'b0, 3'd0, 5'd0, 32'h0, 2'd0);
        bus.query_compressed_i = 1'b1;
        @(negedge clk);
        total++;
        if ({flags(), bus.insn_pc_o} !== {5'b11010, 32'hFFFF_FFFE}) begin
            bad++;
            $display("FAIL wrap_first got flags=%b pc=%h want flags=11010 pc=fffffffe", flags(), bus.insn_pc_o);
        end
        step();
        @(negedge clk);
        $display("beat pc=%h last=%b", bus.insn_pc_o, bus.insn_last_o);
        total++;
        if ({flags(), bus.insn_pc_o, bus.err_o} !== {5'b11110, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL wrap_second got flags=%b pc=%h err=%b want flags=11110 pc=0 err=0",
                     flags(), bus.insn_pc_o, bus.err_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        accept(32'h6000, 8'd6, 1'b1, 3'd0, 5'd0, 32'h0, 2'd1);
        bus.query_compressed_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        total++;
        if ({bus.block_ready_o, flags(), bus.query_addr_o, bus.insn_pc_o, bus.insn_priv_o, bus.err_o} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got ready=%b flags=%b qa=%h pc=%h want all 0",
                     bus.block_ready_o, flags(), bus.query_addr_o, bus.insn_pc_o);
        end
        step();
        rst = 1'b0;
        accept(32'h7000, 8'd2, 1'b1, 3'd0, 5'd0, 32'h0, 2'd0);
        @(negedge clk);
        $display("beat pc=%h last=%b", bus.insn_pc_o, bus.insn_last_o);
        total++;
        if ({flags(), bus.insn_pc_o} !== {5'b11100, 32'h7000}) begin
            bad++;
            $display("FAIL midreset_next got flags=%b pc=%h want flags=11100 pc=7000", flags(), bus.insn_pc_o);
        end
        step();
        @(negedge clk);
        total++;
        if ({bus.insn_valid_o, bus.err_o, bus.block_ready_o} !== 3'b001) begin
            bad++;
            $display("FAIL midreset_after got valid=%b err=%b ready=%b want 0 0 1",
                     bus.insn_valid_o, bus.err_o, bus.block_ready_o);
        end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.block_valid_i      = 1'b0;
        bus.iretire_i          = '0;
        bus.ilastsize_i        = 1'b0;
        bus.itype_i            = '0;
        bus.cause_i            = '0;
        bus.tval_i             = '0;
        bus.priv_i             = '0;
        bus.iaddr_i            = '0;
        bus.query_compressed_i = 1'b0;
        bus.insn_ready_i       = 1'b1;
        #1;
        test_reset();
        test_expand();
        test_exception();
        test_bad_itype();
        test_underflow();
        test_lastsize();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
